// File: rtl/moesi_pkg.sv
// Shared types and constants for the 4-core MOESI coherence demonstrator.
package moesi_pkg;

  localparam int NUM_CORES = 4;
  localparam int NUM_LINES = 4;
  localparam int ADDR_W    = 3;
  localparam int DATA_W    = 8;
  localparam int MEM_WORDS = 1 << ADDR_W;

  typedef enum logic [2:0] {
    ST_I = 3'd0,
    ST_S = 3'd1,
    ST_E = 3'd2,
    ST_O = 3'd3,
    ST_M = 3'd4
  } line_state_e;

  typedef enum logic [1:0] {
    OP_RD   = 2'd0,
    OP_RDX  = 2'd1,
    OP_UPGR = 2'd2
  } bus_op_e;

  typedef enum logic {
    BUS_IDLE  = 1'b0,
    BUS_SNOOP = 1'b1
  } bus_state_e;

  // A line whose contents differ from memory and must be written back on eviction.
  function automatic logic is_dirty(input logic [2:0] s);
    return (s == ST_M) || (s == ST_O);
  endfunction

endpackage

// File: rtl/moesi_cache.sv
// One core: deterministic traffic generator, private direct-mapped cache,
// hit/miss decode and snoop response. The top owns the bus and memory.
module moesi_cache
  import moesi_pkg::*;
#(
  parameter logic [1:0] CORE_ID = 2'd0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  output logic                              req_o,
  output logic [1:0]                        req_op_o,
  input  logic                              commit_i,
  input  logic [DATA_W-1:0]                 fill_data_i,
  input  logic                              fill_shared_i,
  input  logic                              snoop_valid_i,
  input  logic [1:0]                        snoop_op_i,
  input  logic [ADDR_W-1:0]                 snoop_addr_i,
  output logic                              snoop_hit_o,
  output logic                              snoop_supply_o,
  output logic [NUM_LINES-1:0][2:0]         state_o,
  output logic [NUM_LINES-1:0]              tag_o,
  output logic [NUM_LINES-1:0][DATA_W-1:0]  data_o,
  output logic [3:0]                        req_cnt_o
);

  line_state_e       state_q [NUM_LINES];
  line_state_e       state_d [NUM_LINES];
  logic              tag_q   [NUM_LINES];
  logic              tag_d   [NUM_LINES];
  logic [DATA_W-1:0] data_q  [NUM_LINES];
  logic [DATA_W-1:0] data_d  [NUM_LINES];
  logic [3:0]        req_cnt_q, req_cnt_d;

  logic [ADDR_W-1:0] cur_addr;
  logic [1:0]        cur_idx, snp_idx;
  logic              cur_tag, cur_wr, cur_match, local_hit, local_done;
  logic [DATA_W-1:0] cur_wdata;

  assign cur_addr   = req_cnt_q[2:0];
  assign cur_idx    = cur_addr[1:0];
  assign cur_tag    = cur_addr[2];
  assign cur_wr     = (req_cnt_q[1:0] == CORE_ID);
  assign cur_wdata  = {CORE_ID, 2'b00, req_cnt_q};
  assign cur_match  = (state_q[cur_idx] != ST_I) && (tag_q[cur_idx] == cur_tag);
  assign local_hit  = cur_match && (!cur_wr || state_q[cur_idx] == ST_M || state_q[cur_idx] == ST_E);
  // A local hit on the address being snooped waits a cycle so it cannot race the snoop update.
  assign local_done = local_hit && !(snoop_valid_i && (snoop_addr_i == cur_addr));

  assign req_o    = !local_hit;
  assign req_op_o = !cur_wr ? OP_RD : (cur_match ? OP_UPGR : OP_RDX);

  assign snp_idx        = snoop_addr_i[1:0];
  assign snoop_hit_o    = (state_q[snp_idx] != ST_I) && (tag_q[snp_idx] == snoop_addr_i[2]);
  assign snoop_supply_o = snoop_hit_o && is_dirty(state_q[snp_idx]);

  // Next-state: snoop downgrade/invalidate, bus commit as requester, or local hit.
  always_comb begin
    state_d   = state_q;
    tag_d     = tag_q;
    data_d    = data_q;
    req_cnt_d = req_cnt_q;
    if (snoop_valid_i && snoop_hit_o) begin
      if (snoop_op_i == OP_RD) begin
        if (state_q[snp_idx] == ST_M)      state_d[snp_idx] = ST_O;
        else if (state_q[snp_idx] == ST_E) state_d[snp_idx] = ST_S;
      end else begin
        state_d[snp_idx] = ST_I;
      end
    end
    if (commit_i) begin
      tag_d[cur_idx] = cur_tag;
      req_cnt_d      = req_cnt_q + 4'd1;
      if (cur_wr) begin
        state_d[cur_idx] = ST_M;
        data_d[cur_idx]  = cur_wdata;
      end else begin
        state_d[cur_idx] = fill_shared_i ? ST_S : ST_E;
        data_d[cur_idx]  = fill_data_i;
      end
    end else if (local_done) begin
      req_cnt_d = req_cnt_q + 4'd1;
      if (cur_wr) begin
        state_d[cur_idx] = ST_M;
        data_d[cur_idx]  = cur_wdata;
      end
    end
  end

  // Cache arrays and request counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_cnt_q <= 4'd0;
      for (int i = 0; i < NUM_LINES; i++) begin
        state_q[i] <= ST_I;
        tag_q[i]   <= 1'b0;
        data_q[i]  <= '0;
      end
    end else begin
      req_cnt_q <= req_cnt_d;
      state_q   <= state_d;
      tag_q     <= tag_d;
      data_q    <= data_d;
    end
  end

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_obs
    assign state_o[gi] = state_q[gi];
    assign tag_o[gi]   = tag_q[gi];
    assign data_o[gi]  = data_q[gi];
  end
  assign req_cnt_o = req_cnt_q;

endmodule

// File: rtl/moesi_4core_top.sv
// Four MOESI caches on one snooping bus with round-robin arbitration,
// a two-state bus FSM and a shared 8-word memory.
module moesi_4core_top
  import moesi_pkg::*;
(
  input logic clk,
  input logic rst_n
);

  logic [NUM_CORES-1:0]                              req, commit, snoop_valid, snoop_hit, snoop_supply;
  logic [NUM_CORES-1:0][1:0]                         req_op;
  logic [NUM_CORES-1:0][NUM_LINES-1:0][2:0]          line_state;
  logic [NUM_CORES-1:0][NUM_LINES-1:0]               line_tag;
  logic [NUM_CORES-1:0][NUM_LINES-1:0][DATA_W-1:0]   line_data;
  logic [NUM_CORES-1:0][3:0]                         req_cnt;
  logic [DATA_W-1:0]                                 mem [MEM_WORDS];

  bus_state_e        bus_state_q, bus_state_d, bus_state;
  logic [1:0]        bus_owner_q, bus_owner_d, bus_owner;
  logic              bus_busy;
  logic              grant_found, fill_shared, victim_wb;
  logic [1:0]        grant_idx, arb_cand, own_idx;
  logic [1:0]        own_op;
  logic [ADDR_W-1:0] own_addr, victim_addr;
  logic [DATA_W-1:0] fill_data;

  assign bus_state = bus_state_q;
  assign bus_owner = bus_owner_q;
  assign bus_busy  = (bus_state == BUS_SNOOP);

  // The owner's pending request is stable while it stalls, so it is broadcast directly.
  assign own_op   = req_op[bus_owner];
  assign own_addr = req_cnt[bus_owner][2:0];
  assign own_idx  = own_addr[1:0];

  // Round-robin: first requester at or after bus_owner+1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = bus_owner_q;
    arb_cand    = bus_owner_q;
    for (int k = 1; k <= NUM_CORES; k++) begin
      arb_cand = bus_owner_q + k[1:0];
      if (!grant_found && req[arb_cand]) begin
        grant_found = 1'b1;
        grant_idx   = arb_cand;
      end
    end
  end

  // Bus FSM next state: grant in IDLE, commit and release in SNOOP.
  always_comb begin
    bus_state_d = bus_state_q;
    bus_owner_d = bus_owner_q;
    if (bus_state_q == BUS_IDLE) begin
      if (grant_found) begin
        bus_state_d = BUS_SNOOP;
        bus_owner_d = grant_idx;
      end
    end else begin
      bus_state_d = BUS_IDLE;
    end
  end

  // Bus FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_state_q <= BUS_IDLE;
      bus_owner_q <= 2'd3;
    end else begin
      bus_state_q <= bus_state_d;
      bus_owner_q <= bus_owner_d;
    end
  end

  // Fill source: a dirty holder supplies data, otherwise memory; any other copy means shared.
  always_comb begin
    fill_data   = mem[own_addr];
    fill_shared = 1'b0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (snoop_valid[c] && snoop_hit[c]) begin
        fill_shared = 1'b1;
        if (snoop_supply[c]) fill_data = line_data[c][own_idx];
      end
    end
  end

  assign victim_addr = {line_tag[bus_owner][own_idx], own_idx};
  assign victim_wb   = bus_busy && (line_tag[bus_owner][own_idx] != own_addr[2])
                       && is_dirty(line_state[bus_owner][own_idx]);

  // Shared memory: reset to mem[a] = a, written only by dirty victims at commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < MEM_WORDS; a++) mem[a] <= DATA_W'(a);
    end else if (victim_wb) begin
      mem[victim_addr] <= line_data[bus_owner][own_idx];
    end
  end

  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
    assign commit[gi]      = bus_busy && (bus_owner == 2'(gi));
    assign snoop_valid[gi] = bus_busy && (bus_owner != 2'(gi));

    moesi_cache #(.CORE_ID(2'(gi))) u_cache (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_o          (req[gi]),
      .req_op_o       (req_op[gi]),
      .commit_i       (commit[gi]),
      .fill_data_i    (fill_data),
      .fill_shared_i  (fill_shared),
      .snoop_valid_i  (snoop_valid[gi]),
      .snoop_op_i     (own_op),
      .snoop_addr_i   (own_addr),
      .snoop_hit_o    (snoop_hit[gi]),
      .snoop_supply_o (snoop_supply[gi]),
      .state_o        (line_state[gi]),
      .tag_o          (line_tag[gi]),
      .data_o         (line_data[gi]),
      .req_cnt_o      (req_cnt[gi])
    );
  end

endmodule

// File: tb/tb_moesi_4core_top.sv
// Bench for moesi_4core_top: scoreboarded cold-start transactions, dirty
// eviction, mid-transaction reset and a coherence/progress run.
`timescale 1ns/1ps
module tb_moesi_4core_top;
  import moesi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  moesi_4core_top dut (.clk(clk), .rst_n(rst_n));

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int txn_cnt = 0;
  bit cold_timed = 1'b0;

  typedef struct {
    int txn;
    int owner;
    int core;
    int idx;
    int st;
    int data;   // negative: do not check data
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic push(input int t, input int o, input int c, input int i, input int s, input int d);
    exp_t e;
    e.txn = t; e.owner = o; e.core = c; e.idx = i; e.st = s; e.data = d;
    sb_q.push_back(e);
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  // Monitor: every completed bus transaction pops and checks its expectations.
  initial begin : monitor
    exp_t e;
    int owner;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        txn_cnt = 0;
        continue;
      end
      if (dut.bus_state == BUS_SNOOP) begin
        owner = int'(dut.bus_owner);
        @(posedge clk);
        #1;
        if (rst_n !== 1'b1) begin
          txn_cnt = 0;
          continue;
        end
        while (sb_q.size() > 0 && sb_q[0].txn == txn_cnt) begin
          e = sb_q.pop_front();
          chk($sformatf("txn%0d grant", txn_cnt), owner, e.owner);
          chk($sformatf("txn%0d core%0d line%0d state", txn_cnt, e.core, e.idx),
              dut.line_state[e.core][e.idx], e.st);
          if (e.data >= 0)
            chk($sformatf("txn%0d core%0d line%0d data", txn_cnt, e.core, e.idx),
                dut.line_data[e.core][e.idx], e.data);
        end
        if (txn_cnt == 3 && !cold_timed) begin
          cold_timed = 1'b1;
          chk("cold start done by cycle 8", cyc <= 8, 1);
        end
        txn_cnt++;
      end
    end
  end

  task automatic check_reset_state(input string tag);
    int bad_lines;
    bad_lines = 0;
    for (int c = 0; c < NUM_CORES; c++)
      for (int i = 0; i < NUM_LINES; i++)
        if (dut.line_state[c][i] != ST_I || dut.line_tag[c][i] != 1'b0 || dut.line_data[c][i] != 8'h00)
          bad_lines++;
    chk({tag, " lines I/0"}, bad_lines, 0);
    for (int c = 0; c < NUM_CORES; c++)
      chk($sformatf("%s req_cnt[%0d]", tag, c), dut.req_cnt[c], 0);
    chk({tag, " mem[5]"}, dut.mem[5], 5);
    chk({tag, " mem[1]"}, dut.mem[1], 1);
    chk({tag, " bus_state"}, dut.bus_state, BUS_IDLE);
    chk({tag, " bus_owner"}, dut.bus_owner, 3);
    chk({tag, " bus_busy"}, dut.bus_busy, 0);
  endtask

  initial begin : stimulus
    int guard;
    logic [7:0] golden [8];
    logic [3:0] prev_cnt [NUM_CORES];
    int adv [NUM_CORES];

    // Reset held for two cycles.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");

    // Cold start: hand-derived transaction sequence.
    push(0, 0, 0, 0, ST_M, 8'h00);
    push(1, 1, 0, 0, ST_O, 8'h00);
    push(1, 1, 1, 0, ST_S, 8'h00);
    push(2, 2, 2, 0, ST_S, 8'h00);
    push(3, 3, 3, 0, ST_S, 8'h00);
    push(4, 0, 0, 1, ST_E, 8'h01);
    push(5, 1, 1, 1, ST_M, 8'h41);
    push(5, 1, 0, 1, ST_I, -1);
    push(6, 2, 1, 1, ST_O, 8'h41);
    push(6, 2, 2, 1, ST_S, 8'h41);
    push(7, 3, 3, 1, ST_S, 8'h41);
    rst_n = 1'b1;

    guard = 0;
    while (sb_q.size() > 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("cold start scoreboard drained", sb_q.size(), 0);
    chk("mem[1] before eviction", dut.mem[1], 8'h01);

    // Dirty eviction: core1 writes addr5 over its dirty addr1 line.
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(dut.bus_state == BUS_SNOOP && dut.bus_owner == 2'd1 && dut.req_cnt[1] == 4'd5)
               && guard < 200);
    chk("eviction commit reached", guard < 200, 1);
    chk("mem[1] in snoop cycle", dut.mem[1], 8'h01);
    @(posedge clk);
    #1;
    chk("mem[1] after writeback", dut.mem[1], 8'h41);
    chk("core1 line1 state", dut.line_state[1][1], ST_M);
    chk("core1 line1 tag", dut.line_tag[1][1], 1);
    chk("core1 line1 data", dut.line_data[1][1], 8'h45);

    // Mid-run reset during a SNOOP cycle.
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (dut.bus_state != BUS_SNOOP && guard < 20);
    chk("snoop cycle found", dut.bus_state, BUS_SNOOP);
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("mid-run reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset hold");

    // 200-cycle run: coherence invariants, data values and forward progress.
    for (int a = 0; a < 8; a++) golden[a] = 8'(a);
    for (int c = 0; c < NUM_CORES; c++) begin
      prev_cnt[c] = 4'd0;
      adv[c] = 0;
    end
    rst_n = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CORES; c++) begin
        if (dut.req_cnt[c] != prev_cnt[c]) begin
          adv[c]++;
          if (prev_cnt[c][1:0] == 2'(c))
            golden[prev_cnt[c][2:0]] = {2'(c), 2'b00, prev_cnt[c]};
          prev_cnt[c] = dut.req_cnt[c];
        end
      end
      for (int a = 0; a < 8; a++) begin
        int n_valid, n_own, n_exc, n_bad_data;
        logic [2:0] st;
        n_valid = 0; n_own = 0; n_exc = 0; n_bad_data = 0;
        for (int c = 0; c < NUM_CORES; c++) begin
          st = dut.line_state[c][a % 4];
          if (st != ST_I && dut.line_tag[c][a % 4] == 1'(a / 4)) begin
            n_valid++;
            if (st == ST_M || st == ST_E || st == ST_O) n_own++;
            if (st == ST_M || st == ST_E) n_exc++;
            if (dut.line_data[c][a % 4] != golden[a]) n_bad_data++;
            if ((st == ST_M || st == ST_O) && n_own > 0) begin end
          end
        end
        if (n_own == 0 || n_exc > 0) begin
          // No dirty owner unless an M/O line is present; clean memory must match.
        end
        chk($sformatf("cyc%0d addr%0d coherence", n, a),
            (n_own <= 1) && (n_exc == 0 || n_valid == 1) && (n_bad_data == 0), 1);
      end
      for (int a = 0; a < 8; a++) begin
        int n_dirty;
        n_dirty = 0;
        for (int c = 0; c < NUM_CORES; c++)
          if ((dut.line_state[c][a % 4] == ST_M || dut.line_state[c][a % 4] == ST_O)
              && dut.line_tag[c][a % 4] == 1'(a / 4))
            n_dirty++;
        if (n_dirty == 0)
          chk($sformatf("cyc%0d mem[%0d] clean", n, a), dut.mem[a], golden[a]);
      end
    end
    for (int c = 0; c < NUM_CORES; c++)
      chk($sformatf("core%0d progress >= 8", c), adv[c] >= 8, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
